uart_case_filter: RTL

UART_CASE_FILTER -- requirements
Module: uart_case_filter

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_case_fifo.sv | 80 ++++++++
 rtl/uart_case_filter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, ASCII constants and case transform for the UART case filter
//
// Purpose : holds the mode enum, the ASCII constants used by the filter,
//           the CRLF state type and the byte case-transform helper.
// Ports   : none (package).
// Config  : the CRLF state type is only used when UART_CASE_FILTER_CRLF_EN is defined.

package uart_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_UPPER  = 2'd1,
    MODE_LOWER  = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_e;

  typedef enum logic {
    CRLF_IDLE   = 1'b0,
    CRLF_INS_LF = 1'b1
  } crlf_state_e;

  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CASE_BIT = 8'h20;

  // Only ASCII letters are ever touched; everything else passes unchanged.
  function automatic logic [7:0] apply_case(input logic [7:0] b, input mode_e m);
    logic       is_lo;
    logic       is_up;
    logic [7:0] r;
    is_lo = (b >= 8'h61) && (b <= 8'h7A);
    is_up = (b >= 8'h41) && (b <= 8'h5A);
    r     = b;
    case (m)
      MODE_UPPER:  if (is_lo)          r = b - CASE_BIT;
      MODE_LOWER:  if (is_up)          r = b + CASE_BIT;
      MODE_TOGGLE: if (is_lo || is_up) r = b ^ CASE_BIT;
      default:                         r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_case_fifo.sv
// rtl/uart_case_fifo.sv - first-word-fall-through byte FIFO with occupancy output
//
// Purpose : DEPTH-entry, 8-bit FWFT FIFO. The head entry is always visible on
//           o_rdata while o_empty is low. Pointers wrap modulo DEPTH.
// Ports   : i_clk, i_rst (sync, active-high)
//           i_push, i_wdata   write request / data (honoured if not full, or
//                             if full and a pop happens in the same cycle)
//           i_pop             read request (ignored while empty)
//           o_rdata           head entry
//           o_empty, o_full   registered status
//           o_level           occupancy 0..DEPTH

module uart_case_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [7:0]               i_wdata,
  input  logic                     i_pop,
  output logic [7:0]               o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_pop   = i_pop && !empty_q;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    do_push  = i_push && (!full_q || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) level_d = level_q + (AW+1)'(1);
    if (!do_push && do_pop) level_d = level_q - (AW+1)'(1);
    empty_d = (level_d == '0);
    full_d  = (level_d == LVL_FULL);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset: nothing is visible until a pointer-tracked write.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_empty = empty_q;
  assign o_full  = full_q;
  assign o_level = level_q;

endmodule

// File: rtl/uart_case_filter.sv
// rtl/uart_case_filter.sv - UART byte case transformer feeding a FWFT FIFO with drop counting
//
// Purpose : applies the selected case transform to each received byte at
//           acceptance, buffers it in uart_case_fifo and presents the head to
//           the transmitter. Bytes that find no room are dropped and counted
//           (saturating).
// Ports   : i_clk, i_rst (sync, active-high)
//           i_mode      0 pass, 1 upper, 2 lower, 3 toggle case
//           i_rx_data, i_rx_valid     receiver byte strobe (no backpressure)
//           o_tx_data, o_tx_valid, i_tx_ready   transmitter handshake
//           o_empty, o_full, o_level  FIFO status
//           o_drop_cnt  discarded byte count
// Config  : UART_CASE_FILTER_CRLF_EN - when defined, every accepted CR is
//           followed by an inserted LF on the next cycle.

module uart_case_filter
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [1:0]               i_mode,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_valid,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [CNT_W-1:0]         o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      level;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [7:0]       rx_xform;
  logic [7:0]       push_data;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

`ifdef UART_CASE_FILTER_CRLF_EN
  localparam logic [AW:0] LVL_ONE_FREE = (AW+1)'(DEPTH - 1);
  crlf_state_e state_q, state_d;
  logic        room_for_pair;
`endif

  always_comb begin
    pop       = !empty && i_tx_ready;
    rx_xform  = apply_case(i_rx_data, mode_e'(i_mode));
    push      = 1'b0;
    push_data = rx_xform;
    drop      = 1'b0;
`ifdef UART_CASE_FILTER_CRLF_EN
    state_d = state_q;
    // CR+LF need two slots; a same-cycle pop counts as one freed slot.
    room_for_pair = (level < LVL_ONE_FREE) || ((level == LVL_ONE_FREE) && pop);
    case (state_q)
      CRLF_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CHAR_CR) begin
            if (room_for_pair) begin
              push    = 1'b1;
              state_d = CRLF_INS_LF;
            end else begin
              drop = 1'b1;
            end
          end else if (!full || pop) begin
            push = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      CRLF_INS_LF: begin
        // The slot was reserved when the CR was accepted, so this always fits.
        push      = 1'b1;
        push_data = CHAR_LF;
        drop      = i_rx_valid;
        state_d   = CRLF_IDLE;
      end
      default: state_d = CRLF_IDLE;
    endcase
`else
    if (i_rx_valid) begin
      if (!full || pop) push = 1'b1;
      else              drop = 1'b1;
    end
`endif
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_cnt_q <= '0;
`ifdef UART_CASE_FILTER_CRLF_EN
      state_q    <= CRLF_IDLE;
`endif
    end else begin
      drop_cnt_q <= drop_cnt_d;
`ifdef UART_CASE_FILTER_CRLF_EN
      state_q    <= state_d;
`endif
    end
  end

  uart_case_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_wdata (push_data),
    .i_pop   (i_tx_ready),
    .o_rdata (o_tx_data),
    .o_empty (empty),
    .o_full  (full),
    .o_level (level)
  );

  assign o_tx_valid = !empty;
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_level    = level;
  assign o_drop_cnt = drop_cnt_q;

endmodule
